// File: rtl/sm_acc_pkg.sv
`default_nettype none
//============================================================================
// Package : sm_acc_pkg
// Brief   : Shared constants and enums for the SincereMicro accumulator stage.
//           DATA_W     - accumulator / operand width (11 only)
//           c_ACC_MAX  - most positive accumulator value (+1023)
//           c_ACC_MIN  - most negative accumulator value (-1024)
//           op_e       - request op_code encoding
//           state_e    - sequencing FSM states
// Rev     : 1.0  initial release
//============================================================================
package sm_acc_pkg;

   localparam int DATA_W = 11;

   localparam logic signed [DATA_W-1:0] c_ACC_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] c_ACC_MIN = {1'b1, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {
      OP_CLR  = 2'b00,
      OP_LOAD = 2'b01,
      OP_ADD  = 2'b10,
      OP_SUB  = 2'b11
   } op_e;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } state_e;

endpackage : sm_acc_pkg
`default_nettype wire

// File: rtl/acc_sat.sv
`default_nettype none
//============================================================================
// Module : acc_sat
// Brief  : Clips the adder's 12-bit sum back to accumulator width and flags
//          overflow. Purely combinational.
// Ports  : sum_i [DATA_W:0]   in  - full-precision signed sum
//          res_o [DATA_W-1:0] out - clipped result
//          ovf_o              out - sum outside the DATA_W signed range
// Config : ACC_SAT_EN defined   -> saturate to c_ACC_MAX / c_ACC_MIN
//          ACC_SAT_EN undefined -> two's-complement wrap (low DATA_W bits)
// Rev    : 1.0  initial release
//============================================================================
module acc_sat
   import sm_acc_pkg::*;
(
   input  logic [DATA_W:0]   sum_i,
   output logic [DATA_W-1:0] res_o,
   output logic              ovf_o
);

   // The guard bit disagreeing with the result sign bit means the value
   // does not fit in DATA_W bits.
   assign ovf_o = sum_i[DATA_W] ^ sum_i[DATA_W-1];

`ifdef ACC_SAT_EN
   // The guard bit carries the true sign, so it picks the clip direction.
   assign res_o = !ovf_o          ? sum_i[DATA_W-1:0] :
                  sum_i[DATA_W]   ? c_ACC_MIN         : c_ACC_MAX;
`else
   assign res_o = sum_i[DATA_W-1:0];
`endif

endmodule : acc_sat
`default_nettype wire

// File: rtl/add.sv
`default_nettype none
//============================================================================
// Module : add
// Brief  : 11-bit signed adder of the datapath; full-precision 12-bit sum.
// Ports  : acc  [10:0] in  - accumulator operand (signed)
//          arg1 [10:0] in  - second operand (signed)
//          out  [11:0] out - signed sum, one guard bit
// Rev    : 1.0  initial release
//============================================================================
module add (
   input  logic signed [10:0] acc,
   input  logic signed [10:0] arg1,
   output logic signed [11:0] out
);

   // Explicit sign extension keeps the sum exact in 12 bits.
   assign out = {acc[10], acc} + {arg1[10], arg1};

endmodule : add
`default_nettype wire

// File: rtl/acc_reg.sv
`default_nettype none
//============================================================================
// Module : acc_reg
// Brief  : Accumulator stage downstream of the add adder. Accepts one
//          CLR/LOAD/ADD/SUB request at a time over valid/ready, commits the
//          result one cycle after the handshake and pulses done.
// Ports  : clk            in  - system clock, rising edge
//          rst_n          in  - synchronous active-low reset
//          op_valid       in  - request present
//          op_ready       out - block can accept a request (IDLE)
//          op_code  [1:0] in  - 00 CLR, 01 LOAD, 10 ADD, 11 SUB
//          op_arg   [W-1] in  - signed operand
//          done           out - one-cycle pulse after result commit
//          acc      [W-1] out - signed accumulator
//          flag_z         out - acc == 0
//          flag_n         out - acc < 0
//          flag_v         out - sticky overflow (cleared by CLR / reset)
// Config : ACC_SAT_EN selects saturating (defined) or wrapping clip
// Rev    : 1.0  initial release
//============================================================================
module acc_reg #(
   parameter int DATA_W = 11
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     op_valid,
   output logic                     op_ready,
   input  logic [1:0]               op_code,
   input  logic signed [DATA_W-1:0] op_arg,
   output logic                     done,
   output logic signed [DATA_W-1:0] acc,
   output logic                     flag_z,
   output logic                     flag_n,
   output logic                     flag_v
);
   import sm_acc_pkg::*;

   state_e                    state_q, state_d;
   op_e                       op_q, op_d;
   logic signed [DATA_W-1:0]  arg_q, arg_d;
   logic signed [DATA_W-1:0]  acc_q, acc_d;
   logic                      flag_v_q, flag_v_d;
   logic                      done_q, done_d;

   logic                      w_neg_sat;
   logic signed [DATA_W-1:0]  w_operand;
   logic signed [DATA_W:0]    w_sum;
   logic [DATA_W-1:0]         w_res;
   logic                      w_ovf;

   // -(-1024) is not representable: substitute +1023 and report it as an
   // overflow event at commit.
   assign w_neg_sat = (arg_q == c_ACC_MIN);

   always_comb begin
      w_operand = arg_q;
      if (op_q == OP_SUB) begin
         w_operand = w_neg_sat ? c_ACC_MAX : -arg_q;
      end
   end

   add u_add (
      .acc  (acc_q),
      .arg1 (w_operand),
      .out  (w_sum)
   );

   acc_sat u_acc_sat (
      .sum_i (w_sum),
      .res_o (w_res),
      .ovf_o (w_ovf)
   );

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      arg_d    = arg_q;
      acc_d    = acc_q;
      flag_v_d = flag_v_q;
      done_d   = 1'b0;
      op_ready = 1'b0;
      case (state_q)
         ST_IDLE: begin
            op_ready = 1'b1;
            if (op_valid) begin
               op_d    = op_e'(op_code);
               arg_d   = op_arg;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            case (op_q)
               OP_CLR: begin
                  acc_d    = '0;
                  flag_v_d = 1'b0;
               end
               OP_LOAD: begin
                  acc_d = arg_q;
               end
               OP_ADD: begin
                  acc_d    = w_res;
                  flag_v_d = flag_v_q | w_ovf;
               end
               OP_SUB: begin
                  acc_d    = w_res;
                  flag_v_d = flag_v_q | w_ovf | w_neg_sat;
               end
               default: begin
                  acc_d = acc_q;
               end
            endcase
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_CLR;
         arg_q    <= '0;
         acc_q    <= '0;
         flag_v_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         arg_q    <= arg_d;
         acc_q    <= acc_d;
         flag_v_q <= flag_v_d;
         done_q   <= done_d;
      end
   end

   assign acc    = acc_q;
   assign done   = done_q;
   assign flag_v = flag_v_q;
   assign flag_z = (acc_q == '0);
   assign flag_n = acc_q[DATA_W-1];

endmodule : acc_reg
`default_nettype wire

// File: tb/tb_acc_reg.sv
`default_nettype none
//============================================================================
// Module : tb_acc_reg
// Brief  : Self-checking bench for acc_reg. Table of requests with expected
//          accumulator/overflow results; expectations are queued at the
//          handshake and checked when done pulses. Hand-written sequences
//          cover reset during EXEC and a back-to-back stream.
// Config : ACC_SAT_EN selects the saturating expectations
// Rev    : 1.0  initial release
//============================================================================
module tb_acc_reg;

   localparam logic [1:0] c_CLR  = 2'b00;
   localparam logic [1:0] c_LOAD = 2'b01;
   localparam logic [1:0] c_ADD  = 2'b10;
   localparam logic [1:0] c_SUB  = 2'b11;

`ifdef ACC_SAT_EN
   localparam logic signed [10:0] c_E_POS_OVF = 11'sd1023;   // 900+900
   localparam logic signed [10:0] c_E_NEG_OVF = -11'sd1024;  // -900-900
   localparam logic signed [10:0] c_E_SUB3    = -11'sd1024;  // -1024-3
   localparam logic signed [10:0] c_E_1023P1  = 11'sd1023;   // 1023+1
`else
   localparam logic signed [10:0] c_E_POS_OVF = -11'sd248;
   localparam logic signed [10:0] c_E_NEG_OVF = 11'sd248;
   localparam logic signed [10:0] c_E_SUB3    = 11'sd245;    // 248-3
   localparam logic signed [10:0] c_E_1023P1  = -11'sd1024;
`endif

   typedef struct {
      logic [1:0]        code;
      logic signed [10:0] arg;
      logic signed [10:0] exp_acc;
      logic              exp_v;
   } vec_t;

   typedef struct {
      logic signed [10:0] acc;
      logic              v;
      int                hs;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              op_valid = 1'b0;
   logic              op_ready;
   logic [1:0]        op_code = 2'b00;
   logic signed [10:0] op_arg = '0;
   logic              done;
   logic signed [10:0] acc;
   logic              flag_z, flag_n, flag_v;

   int   n_cmp = 0;
   int   n_err = 0;
   int   cycle_cnt = 0;
   exp_t exp_q[$];
   vec_t vecs[$];

   acc_reg #(.DATA_W(11)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .op_valid (op_valid),
      .op_ready (op_ready),
      .op_code  (op_code),
      .op_arg   (op_arg),
      .done     (done),
      .acc      (acc),
      .flag_z   (flag_z),
      .flag_n   (flag_n),
      .flag_v   (flag_v)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle_cnt);
      end
   endtask

   // Scoreboard: every done pulse consumes one queued expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_done: got done=1, expected no pending op (cycle %0d)", cycle_cnt);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("acc",          int'(acc),    int'(e.acc));
            check("flag_v",       int'(flag_v), int'(e.v));
            check("flag_z",       int'(flag_z), int'(e.acc == 0));
            check("flag_n",       int'(flag_n), int'(e.acc < 0));
            check("done_latency", cycle_cnt,    e.hs + 1);
         end
      end
   end

   // Present a request at a negedge and hold it until accepted. With keep=1
   // op_valid stays high afterwards; op_code/op_arg are scrambled during
   // EXEC either way so any late sampling would corrupt the result.
   task automatic do_op(input logic [1:0] c, input logic signed [10:0] a,
                        input logic signed [10:0] ea, input logic ev,
                        input bit keep, output int hs);
      int   w;
      exp_t e;
      w  = 0;
      hs = -1;
      @(negedge clk);
      op_valid = 1'b1;
      op_code  = c;
      op_arg   = a;
      while (!op_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!op_ready) begin
         n_cmp++;
         n_err++;
         $display("FAIL ready_timeout: got op_ready=0 for 20 cycles, expected 1");
         op_valid = 1'b0;
      end else begin
         hs    = cycle_cnt + 1;
         e.acc = ea;
         e.v   = ev;
         e.hs  = hs;
         exp_q.push_back(e);
         @(negedge clk);
         check("ready_in_exec", int'(op_ready), 0);
         op_valid = keep;
         op_code  = ~c;
         op_arg   = 11'($urandom);
      end
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 20) begin
         @(negedge clk);
         w++;
      end
      @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain_timeout: got %0d pending ops, expected 0", exp_q.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs, prev_hs;

      vecs.push_back('{c_LOAD, 11'sd900,   11'sd900,    1'b0});
      vecs.push_back('{c_ADD,  11'sd900,   c_E_POS_OVF, 1'b1});
      vecs.push_back('{c_CLR,  11'sd0,     11'sd0,      1'b0});
      vecs.push_back('{c_LOAD, -11'sd900,  -11'sd900,   1'b0});
      vecs.push_back('{c_ADD,  -11'sd105,  -11'sd1005,  1'b0});
      vecs.push_back('{c_LOAD, -11'sd25,   -11'sd25,    1'b0});
      vecs.push_back('{c_ADD,  11'sd27,    11'sd2,      1'b0});
      vecs.push_back('{c_CLR,  11'sd0,     11'sd0,      1'b0});
      vecs.push_back('{c_SUB,  -11'sd1024, 11'sd1023,   1'b1});
      vecs.push_back('{c_LOAD, 11'sd5,     11'sd5,      1'b1});
      vecs.push_back('{c_CLR,  11'sd0,     11'sd0,      1'b0});
      vecs.push_back('{c_LOAD, -11'sd900,  -11'sd900,   1'b0});
      vecs.push_back('{c_ADD,  -11'sd900,  c_E_NEG_OVF, 1'b1});
      vecs.push_back('{c_SUB,  11'sd3,     c_E_SUB3,    1'b1});
      vecs.push_back('{c_CLR,  11'sd0,     11'sd0,      1'b0});
      vecs.push_back('{c_LOAD, 11'sd100,   11'sd100,    1'b0});
      vecs.push_back('{c_SUB,  -11'sd200,  11'sd300,    1'b0});
      vecs.push_back('{c_LOAD, 11'sd1000,  11'sd1000,   1'b0});
      vecs.push_back('{c_ADD,  11'sd23,    11'sd1023,   1'b0});
      vecs.push_back('{c_ADD,  11'sd1,     c_E_1023P1,  1'b1});
      vecs.push_back('{c_CLR,  11'sd0,     11'sd0,      1'b0});

      // Reset values
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_ready",  int'(op_ready), 1);
      check("rst_done",   int'(done),     0);
      check("rst_acc",    int'(acc),      0);
      check("rst_flag_z", int'(flag_z),   1);
      check("rst_flag_n", int'(flag_n),   0);
      check("rst_flag_v", int'(flag_v),   0);

      // Reset while a LOAD is in EXEC discards it
      do_op(c_LOAD, 11'sd7, 11'sd7, 1'b0, 1'b0, hs);
      wait_idle();
      op_valid = 1'b1;
      op_code  = c_LOAD;
      op_arg   = 11'sd500;
      @(negedge clk);              // handshake edge has passed: EXEC
      op_valid = 1'b0;
      rst_n    = 1'b0;
      @(negedge clk);              // reset sampled
      rst_n = 1'b1;
      check("midrst_acc",    int'(acc),      0);
      check("midrst_flag_z", int'(flag_z),   1);
      check("midrst_ready",  int'(op_ready), 1);
      check("midrst_done",   int'(done),     0);
      @(negedge clk);
      check("midrst_done2",  int'(done),     0);
      check("midrst_acc2",   int'(acc),      0);

      // Table-driven requests
      for (int i = 0; i < vecs.size(); i++) begin
         do_op(vecs[i].code, vecs[i].arg, vecs[i].exp_acc, vecs[i].exp_v, 1'b0, hs);
      end
      wait_idle();

      // Back-to-back stream with op_valid held high
      do_op(c_LOAD, 11'sd50,  11'sd50,  1'b0, 1'b1, prev_hs);
      do_op(c_ADD,  11'sd50,  11'sd100, 1'b0, 1'b1, hs);
      check("b2b_interval1", hs - prev_hs, 2);
      prev_hs = hs;
      do_op(c_SUB,  11'sd100, 11'sd0,   1'b0, 1'b0, hs);
      check("b2b_interval2", hs - prev_hs, 2);
      wait_idle();
      check("end_flag_z", int'(flag_z),   1);
      check("end_ready",  int'(op_ready), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_acc_reg
`default_nettype wire
